// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbolizer and the downstream decoder.
// Holds the 2-bit symbol encodings, the symbolizer FSM states, the duration
// counter type and the default timing thresholds (in clock cycles).
package morse_pkg;

  // Symbol encodings carried on sym_data
  typedef enum logic [1:0] {
    SYM_DOT        = 2'b00,
    SYM_DASH       = 2'b01,
    SYM_LETTER_END = 2'b10,
    SYM_WORD_END   = 2'b11
  } sym_e;

  // Symbolizer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MARK  = 2'b01,
    ST_SPACE = 2'b10
  } state_e;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_DEBOUNCE_CYC = 3;
  localparam int DEF_DASH_MIN     = 60;
  localparam int DEF_LETTER_GAP   = 150;
  localparam int DEF_WORD_GAP     = 350;
  localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/morse_sym_fifo.sv
// Small synchronous FIFO holding pending Morse symbols.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   pop_data          head entry, combinational from the storage array
//   full, empty       occupancy flags
// DEPTH must be a power of 2 and at least 2.
module morse_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot this cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head reads as 00 while empty.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
          mem_q[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/morse_symbolizer.sv
// Converts a raw Morse key line into a stream of DOT / DASH / LETTER_END /
// WORD_END symbols with a valid/ready output queue.
// Ports:
//   cpuclock   single clock, rising edge
//   resetn     asynchronous active-low reset
//   morse      raw asynchronous key input, 1 = mark
//   sym_data   head symbol (see morse_pkg encodings)
//   sym_valid  sym_data holds a valid symbol
//   sym_ready  downstream accepts the head symbol
//   overflow   sticky: a symbol was dropped because the queue was full
module morse_symbolizer #(
  parameter int DEBOUNCE_CYC = morse_pkg::DEF_DEBOUNCE_CYC,
  parameter int DASH_MIN     = morse_pkg::DEF_DASH_MIN,
  parameter int LETTER_GAP   = morse_pkg::DEF_LETTER_GAP,
  parameter int WORD_GAP     = morse_pkg::DEF_WORD_GAP,
  parameter int FIFO_DEPTH   = morse_pkg::DEF_FIFO_DEPTH
) (
  input  logic       cpuclock,
  input  logic       resetn,
  input  logic       morse,
  output logic [1:0] sym_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       overflow
);

  import morse_pkg::*;

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic            deb_rise, deb_fall;
  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic            push;
  logic [1:0]      push_sym;
  logic            pop;
  logic            fifo_full, fifo_empty;

  // Debouncer: the level flips on the edge where sync2 has differed from it
  // for DEBOUNCE_CYC consecutive cycles. The rise/fall strobes are valid in
  // that same cycle so the FSM reacts on the flip edge itself, giving a
  // fixed 2 + DEBOUNCE_CYC latency for both edges.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    deb_rise  = 1'b0;
    deb_fall  = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        deb_d    = sync2_q;
        deb_rise = sync2_q;
        deb_fall = !sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Symbolizer FSM. At most one symbol is pushed per cycle; a rise arriving
  // exactly on a gap threshold still emits that gap symbol.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_sym = SYM_DOT;
    unique case (state_q)
      ST_IDLE: begin
        if (deb_rise) begin
          state_d = ST_MARK;
          cnt_d   = cnt_t'(1);
        end
      end
      ST_MARK: begin
        if (deb_fall) begin
          push     = 1'b1;
          push_sym = (cnt_q < cnt_t'(DASH_MIN)) ? SYM_DOT : SYM_DASH;
          state_d  = ST_SPACE;
          cnt_d    = cnt_t'(1);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SPACE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (cnt_q == cnt_t'(WORD_GAP)) begin
          push     = 1'b1;
          push_sym = SYM_WORD_END;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == cnt_t'(LETTER_GAP)) begin
          push     = 1'b1;
          push_sym = SYM_LETTER_END;
        end
        if (deb_rise) begin
          state_d = ST_MARK;
          cnt_d   = cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop        = sym_valid && sym_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge cpuclock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= morse;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (cpuclock),
    .rst_n     (resetn),
    .push      (push),
    .push_data (push_sym),
    .pop       (pop),
    .pop_data  (sym_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sym_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_morse_symbolizer.sv
// Directed bench for morse_symbolizer with default parameters, 20 ns clock.
module tb_morse_symbolizer;
  import morse_pkg::*;

  logic       cpuclock = 1'b0;
  logic       resetn   = 1'b0;
  logic       morse    = 1'b0;
  logic       sym_ready = 1'b0;
  logic [1:0] sym_data;
  logic       sym_valid;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [1:0] got[$];

  always #10 cpuclock = ~cpuclock;

  morse_symbolizer dut (
    .cpuclock  (cpuclock),
    .resetn    (resetn),
    .morse     (morse),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .overflow  (overflow)
  );

  // Record every symbol that will be popped on the next rising edge.
  always @(negedge cpuclock) begin
    if (resetn && sym_valid && sym_ready) begin
      got.push_back(sym_data);
      $display("[TB] t=%0t popped symbol %0d", $time, sym_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge cpuclock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_got(input string tag, input int idx, input logic [1:0] exp);
    logic [31:0] obs;
    obs = (idx < got.size()) ? 32'(got[idx]) : 32'hFFFF_FFFF;
    check(tag, obs, 32'(exp));
  endtask

  task automatic press(input int n);
    morse = 1'b1;
    tick(n);
    morse = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    morse  = 1'b0;
    tick(3);
    resetn = 1'b1;
    got.delete();
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_data", 32'(sym_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    resetn = 1'b1;
    tick(2);

    // Five dashes, then a letter gap reached exactly on cycle 150
    sym_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press(120);
      if (i < 4) tick(5);
    end
    tick(154);
    check("dash_count_pre_gap", 32'(got.size()), 32'd5);
    check("gap149_valid", 32'(sym_valid), 32'd0);
    tick(1);
    check("gap150_valid", 32'(sym_valid), 32'd1);
    check("gap150_data", 32'(sym_data), 32'(SYM_LETTER_END));
    tick(45);
    check("dash_run_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 5; i++) check_got("dash_run_sym", i, SYM_DASH);
    check_got("dash_run_letter", 5, SYM_LETTER_END);

    // DOT/DASH boundary, then letter and word gaps
    do_reset();
    press(59);
    tick(10);
    press(60);
    tick(400);
    check("bound_count", 32'(got.size()), 32'd4);
    check_got("bound_59", 0, SYM_DOT);
    check_got("bound_60", 1, SYM_DASH);
    check_got("bound_letter", 2, SYM_LETTER_END);
    check_got("bound_word", 3, SYM_WORD_END);
    check("bound_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Glitches of 1 and 2 cycles are rejected
    do_reset();
    press(1);
    tick(20);
    press(2);
    tick(20);
    check("glitch_count", 32'(got.size()), 32'd0);
    check("glitch_valid", 32'(sym_valid), 32'd0);
    check("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Overflow: six dots with no consumer, four retained
    do_reset();
    sym_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      press(20);
      tick(10);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(sym_valid), 32'd1);
    check("ovf_head", 32'(sym_data), 32'(SYM_DOT));
    sym_ready = 1'b1;
    tick(10);
    check("ovf_drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_got("ovf_drain_sym", i, SYM_DOT);
    check("ovf_drain_valid", 32'(sym_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-press clears everything at once
    do_reset();
    sym_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(20);
      tick(10);
    end
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    morse = 1'b1;
    tick(60);
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(sym_valid), 32'd0);
    check("async_rst_data", 32'(sym_data), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick(3);
    resetn = 1'b1;
    got.delete();
    sym_ready = 1'b1;
    tick(4);
    check("rel_no_mark_yet", 32'(dut.state_q), 32'(ST_IDLE));
    check("rel_no_symbol", 32'(sym_valid), 32'd0);
    tick(1);
    check("rel_fresh_mark", 32'(dut.state_q), 32'(ST_MARK));
    tick(52);
    morse = 1'b0;
    tick(10);
    check("rel_dot_count", 32'(got.size()), 32'd1);
    check_got("rel_dot", 0, SYM_DOT);
    check("rel_overflow", 32'(overflow), 32'd0);

    // Stall stability with sym_ready toggling
    do_reset();
    sym_ready = 1'b0;
    press(20);
    tick(10);
    press(70);
    tick(10);
    check("stall_head0", 32'(sym_data), 32'(SYM_DOT));
    tick(3);
    check("stall_hold0", 32'(sym_data), 32'(SYM_DOT));
    check("stall_valid0", 32'(sym_valid), 32'd1);
    sym_ready = 1'b1;
    tick(1);
    sym_ready = 1'b0;
    check("stall_pop1", 32'(got.size()), 32'd1);
    check("stall_head1", 32'(sym_data), 32'(SYM_DASH));
    tick(3);
    check("stall_hold1", 32'(sym_data), 32'(SYM_DASH));
    sym_ready = 1'b1;
    tick(1);
    sym_ready = 1'b0;
    check("stall_pop2", 32'(got.size()), 32'd2);
    check_got("stall_first", 0, SYM_DOT);
    check_got("stall_second", 1, SYM_DASH);
    check("stall_empty", 32'(sym_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_symbolizer.md
MORSE_SYMBOLIZER -- requirements
Module: morse_symbolizer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 3: cycles the synchronized key must hold a new level before it is accepted.
REQ-002 SHALL have parameter DASH_MIN, default 60: a mark of at least this many cycles is a dash.
REQ-003 SHALL have parameter LETTER_GAP, default 150: space cycles at which LETTER_END is emitted.
REQ-004 SHALL have parameter WORD_GAP, default 350: space cycles at which WORD_END is emitted; WORD_GAP > LETTER_GAP.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: symbol queue depth, a power of 2.
REQ-006 cpuclock  input  1  single clock; all state on rising edge.
REQ-007 resetn  input  1  reset; asynchronous, active-low.
REQ-008 morse  input  1  raw key line, asynchronous; 1 = key pressed (mark).
REQ-009 sym_data  output  2  head symbol: 00 DOT, 01 DASH, 10 LETTER_END, 11 WORD_END.
REQ-010 sym_valid  output  1  sym_data holds a valid symbol.
REQ-011 sym_ready  input  1  downstream decoder accepts the head symbol.
REQ-012 overflow  output  1  sticky; a symbol was dropped.

Function
REQ-013 morse SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level flips only after DEBOUNCE_CYC consecutive cycles at the new level.
REQ-014 FSM states SHALL be IDLE, MARK and SPACE; IDLE after reset.
REQ-015 IDLE->MARK on a debounced rise; the 16-bit duration counter loads 1.
REQ-016 MARK SHALL increment the counter each cycle, saturating at 0xFFFF.
REQ-017 MARK->SPACE on a debounced fall; on that edge push DOT if counter < DASH_MIN, else DASH; counter loads 1.
REQ-018 SPACE SHALL increment the counter; at counter == LETTER_GAP push LETTER_END once; at counter == WORD_GAP push WORD_END and go to IDLE.
REQ-019 SPACE->MARK on a debounced rise before WORD_GAP; no gap symbol is pushed for that space if LETTER_GAP was not reached.
REQ-020 IDLE SHALL emit nothing and count nothing; a leading space before the first mark produces no symbols.
REQ-021 Pushed symbols SHALL enter a FIFO_DEPTH FIFO in order; sym_valid rises the cycle after a push into an empty FIFO.
REQ-022 A pop occurs on a cycle with sym_valid && sym_ready; sym_data SHALL be stable while sym_valid && !sym_ready.
REQ-023 A push when full without a same-cycle pop SHALL drop the new symbol and set overflow; a push when full with a pop SHALL be accepted.
REQ-024 A push and a pop when empty SHALL be impossible (no bypass); sym_valid=0 means sym_data is don't-care but driven.
REQ-025 Latency morse rise/fall to debounced edge SHALL be 2 + DEBOUNCE_CYC cycles; both edges are delayed equally, so mark length is preserved.

Reset
REQ-026 While resetn=0: FSM IDLE, counter 0, synchronizer and debounced level 0, FIFO empty, sym_valid=0, sym_data=00, overflow=0.
REQ-027 Reset mid-MARK or mid-SPACE SHALL discard the partial element; after release, a key still held produces a mark only after a fresh debounced rise.
REQ-028 overflow SHALL clear only on reset.

Structure
REQ-029 Shared package morse_pkg SHALL hold the symbol encodings, the FSM state enum and the default threshold constants, so the downstream decoder uses identical encodings.
REQ-030 The FIFO SHALL be the sub-module morse_sym_fifo (parameterized depth, width 2, full/empty outputs); the synchronizer, debouncer and FSM stay in morse_symbolizer.

Verification (20 ns clock, default parameters)
REQ-031 Five 120-cycle presses with 5-cycle gaps, then 200 low cycles, sym_ready=1 -> DASH x5, then one LETTER_END at gap cycle 150, no WORD_END.
REQ-032 Presses of 59 and 60 cycles separated by 10 cycles -> DOT then DASH; hold low 400 cycles -> LETTER_END then WORD_END; FSM ends in IDLE.
REQ-033 Single 1-cycle and 2-cycle high glitches on morse -> no symbol, FSM stays IDLE.
REQ-034 sym_ready=0, six 20-cycle presses with 10-cycle gaps -> 4 DOTs held in order, overflow=1; raising sym_ready drains exactly 4 DOTs.
REQ-035 resetn pulsed low for 3 cycles mid-way through a 120-cycle press -> all outputs reset at once, no symbol on release, overflow=0.
REQ-036 Symbol at head with sym_ready toggling 0/1 -> sym_data stable while stalled; each symbol popped exactly once.
